// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_RD_W   = 5;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic [0:0] {
    StIdle,
    StReq
  } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the memory.
interface mem_stage_if
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_stage_access_fsm.sv
// Data-memory access sequencer: IDLE decision cycle, then REQ until ack or timeout.
module mem_access_fsm
  import mem_stage_pkg::*;
#(
  parameter int unsigned TO_MAX = 255,
  parameter int unsigned TO_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic is_mem_i,
  input  logic misaligned_i,
  input  logic is_write_i,
  input  logic dmem_ack_i,
  output logic dmem_req_o,
  output logic dmem_we_o,
  output logic stall_o,
  output logic mem_fault_o
);

  // Counter value seen in the REQ cycle whose missing ack means TO_MAX cycles have elapsed.
  localparam logic [TO_W-1:0] LastCnt = TO_W'(TO_MAX - 1);

  mem_state_t      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  // State and timeout counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, request strobes, stall and fault pulse.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dmem_req_o  = 1'b0;
    dmem_we_o   = 1'b0;
    stall_o     = 1'b0;
    mem_fault_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (is_mem_i && !misaligned_i) begin
          state_d = StReq;
          stall_o = 1'b1;
        end else if (misaligned_i) begin
          mem_fault_o = 1'b1;
        end
      end
      StReq: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = is_write_i;
        if (dmem_ack_i) begin
          // An ack in the final allowed cycle still wins over the timeout.
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == LastCnt) begin
          mem_fault_o = 1'b1;
          state_d     = StIdle;
          cnt_d       = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          stall_o = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// EX/MEM register, MEM-stage data access and MEM/WB register with forwarding taps.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned RD_W   = DEF_RD_W,
  parameter int unsigned TO_MAX = 255,
  parameter int unsigned TO_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_st_data,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              flush,
  output logic              stall_out,
  output logic [DATA_W-1:0] data_ex_mem,
  mem_stage_if.master       dmem,
  output logic              mem_fault,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] data_mem_wb
);

  logic              exm_valid_q, exm_valid_d;
  logic [DATA_W-1:0] exm_alu_out_q, exm_alu_out_d;
  logic [DATA_W-1:0] exm_st_data_q, exm_st_data_d;
  logic [RD_W-1:0]   exm_rd_q, exm_rd_d;
  logic              exm_reg_write_q, exm_reg_write_d;
  logic              exm_mem_read_q, exm_mem_read_d;
  logic              exm_mem_write_q, exm_mem_write_d;

  logic              wb_valid_q, wb_valid_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic is_mem, misaligned, is_write;

  assign is_mem     = exm_valid_q & (exm_mem_read_q | exm_mem_write_q);
  assign misaligned = is_mem & (|(exm_alu_out_q[1:0] & WORD_ALIGN_MASK));
  // Read wins if both read and write are set.
  assign is_write   = exm_mem_write_q & ~exm_mem_read_q;

  mem_access_fsm #(
    .TO_MAX(TO_MAX),
    .TO_W  (TO_W)
  ) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .is_mem_i    (is_mem),
    .misaligned_i(misaligned),
    .is_write_i  (is_write),
    .dmem_ack_i  (dmem.dmem_ack),
    .dmem_req_o  (dmem.dmem_req),
    .dmem_we_o   (dmem.dmem_we),
    .stall_o     (stall_out),
    .mem_fault_o (mem_fault)
  );

  assign dmem.dmem_addr  = exm_alu_out_q & ~{{(DATA_W-2){1'b0}}, WORD_ALIGN_MASK};
  assign dmem.dmem_wdata = exm_st_data_q;
  assign data_ex_mem     = exm_alu_out_q;

  // EX/MEM reload unless stalled; flush only squashes the incoming instruction.
  always_comb begin
    exm_valid_d     = exm_valid_q;
    exm_alu_out_d   = exm_alu_out_q;
    exm_st_data_d   = exm_st_data_q;
    exm_rd_d        = exm_rd_q;
    exm_reg_write_d = exm_reg_write_q;
    exm_mem_read_d  = exm_mem_read_q;
    exm_mem_write_d = exm_mem_write_q;
    if (!stall_out) begin
      exm_valid_d     = ex_valid & ~flush;
      exm_alu_out_d   = ex_alu_out;
      exm_st_data_d   = ex_st_data;
      exm_rd_d        = ex_rd;
      exm_reg_write_d = ex_reg_write;
      exm_mem_read_d  = ex_mem_read;
      exm_mem_write_d = ex_mem_write;
    end
  end

  // MEM/WB: bubble while stalled or on a fault, otherwise capture the retiring op.
  always_comb begin
    wb_valid_d     = 1'b0;
    wb_reg_write_d = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    if (!stall_out && !mem_fault) begin
      wb_valid_d     = exm_valid_q;
      wb_reg_write_d = exm_valid_q & exm_reg_write_q;
      wb_rd_d        = exm_rd_q;
      wb_data_d      = exm_mem_read_q ? dmem.dmem_rdata : exm_alu_out_q;
    end
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      exm_valid_q     <= 1'b0;
      exm_alu_out_q   <= '0;
      exm_st_data_q   <= '0;
      exm_rd_q        <= '0;
      exm_reg_write_q <= 1'b0;
      exm_mem_read_q  <= 1'b0;
      exm_mem_write_q <= 1'b0;
    end else begin
      exm_valid_q     <= exm_valid_d;
      exm_alu_out_q   <= exm_alu_out_d;
      exm_st_data_q   <= exm_st_data_d;
      exm_rd_q        <= exm_rd_d;
      exm_reg_write_q <= exm_reg_write_d;
      exm_mem_read_q  <= exm_mem_read_d;
      exm_mem_write_q <= exm_mem_write_d;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
    end else begin
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd        = wb_rd_q;
  assign data_mem_wb  = wb_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int unsigned DW     = 32;
  localparam int unsigned RW     = 5;
  localparam int unsigned TO_MAX = 4;
  localparam int unsigned TO_W   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ex_valid = 1'b0;
  logic [DW-1:0] ex_alu_out = '0;
  logic [DW-1:0] ex_st_data = '0;
  logic [RW-1:0] ex_rd = '0;
  logic          ex_reg_write = 1'b0;
  logic          ex_mem_read = 1'b0;
  logic          ex_mem_write = 1'b0;
  logic          flush = 1'b0;
  logic          stall_out;
  logic [DW-1:0] data_ex_mem;
  logic          mem_fault;
  logic          wb_valid;
  logic          wb_reg_write;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] data_mem_wb;

  mem_stage_if #(.DATA_W(DW)) dmem ();

  mem_stage #(
    .DATA_W(DW),
    .RD_W  (RW),
    .TO_MAX(TO_MAX),
    .TO_W  (TO_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_alu_out  (ex_alu_out),
    .ex_st_data  (ex_st_data),
    .ex_rd       (ex_rd),
    .ex_reg_write(ex_reg_write),
    .ex_mem_read (ex_mem_read),
    .ex_mem_write(ex_mem_write),
    .flush       (flush),
    .stall_out   (stall_out),
    .data_ex_mem (data_ex_mem),
    .dmem        (dmem),
    .mem_fault   (mem_fault),
    .wb_valid    (wb_valid),
    .wb_reg_write(wb_reg_write),
    .wb_rd       (wb_rd),
    .data_mem_wb (data_mem_wb)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the instruction sitting in MEM, whether its bus request is open, how many
  // REQ cycles it has waited, and the MEM/WB contents.
  logic          m_valid = 1'b0, m_rw = 1'b0, m_mr = 1'b0, m_mw = 1'b0;
  logic [DW-1:0] m_alu = '0, m_st = '0;
  logic [RW-1:0] m_rd = '0;
  bit            open = 1'b0;
  int            waited = 0;
  logic          w_valid = 1'b0, w_rw = 1'b0;
  logic [RW-1:0] w_rd = '0;
  logic [DW-1:0] w_data = '0;

  logic e_mem, e_mis, e_stall, e_fault, e_done;

  // Compare DUT against the model, then advance the model over the coming edge.
  always @(negedge clk) begin
    e_mem   = m_valid && (m_mr || m_mw);
    e_mis   = e_mem && (m_alu[1:0] != 2'b00);
    e_stall = 1'b0;
    e_fault = 1'b0;
    e_done  = 1'b0;
    if (!open) begin
      e_fault = e_mis;
      e_stall = e_mem && !e_mis;
    end else if (dmem.dmem_ack) begin
      e_done = 1'b1;
    end else if (waited + 1 == TO_MAX) begin
      e_fault = 1'b1;
    end else begin
      e_stall = 1'b1;
    end

    if (chk_en) begin
      chk("stall_out", stall_out, e_stall);
      chk("mem_fault", mem_fault, e_fault);
      chk("dmem_req", dmem.dmem_req, open);
      chk("dmem_we", dmem.dmem_we, open && m_mw && !m_mr);
      chk("data_ex_mem", data_ex_mem, m_alu);
      if (open) begin
        chk("dmem_addr", dmem.dmem_addr, {m_alu[31:2], 2'b00});
        chk("dmem_wdata", dmem.dmem_wdata, m_st);
      end
      chk("wb_valid", wb_valid, w_valid);
      chk("wb_reg_write", wb_reg_write, w_rw);
      if (w_valid) begin
        chk("wb_rd", wb_rd, w_rd);
        chk("data_mem_wb", data_mem_wb, w_data);
      end
    end

    if (rst) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_alu = '0; m_st = '0; m_rd = '0;
      open = 0; waited = 0;
      w_valid = 0; w_rw = 0; w_rd = '0; w_data = '0;
    end else begin
      if (e_stall || e_fault) begin
        w_valid = 0;
        w_rw    = 0;
      end else begin
        w_valid = m_valid;
        w_rw    = m_valid && m_rw;
        w_rd    = m_rd;
        w_data  = m_mr ? dmem.dmem_rdata : m_alu;
      end
      if (!open) begin
        open   = e_mem && !e_mis;
        waited = 0;
      end else if (e_done || e_fault) begin
        open   = 0;
        waited = 0;
      end else begin
        waited++;
      end
      if (!e_stall) begin
        m_valid = ex_valid && !flush;
        m_alu   = ex_alu_out;
        m_st    = ex_st_data;
        m_rd    = ex_rd;
        m_rw    = ex_reg_write;
        m_mr    = ex_mem_read;
        m_mw    = ex_mem_write;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [DW-1:0] alu, input logic [DW-1:0] st,
                        input logic [RW-1:0] rd, input logic rw, input logic mr,
                        input logic mw);
    ex_valid     = v;
    ex_alu_out   = alu;
    ex_st_data   = st;
    ex_rd        = rd;
    ex_reg_write = rw;
    ex_mem_read  = mr;
    ex_mem_write = mw;
  endtask

  task automatic set_nop();
    set_ex(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [31:0] r;

  initial begin
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = '0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset stall_out", stall_out, 1'b0);
    chk("reset dmem_req", dmem.dmem_req, 1'b0);
    chk("reset wb_valid", wb_valid, 1'b0);
    chk("reset data_mem_wb", data_mem_wb, 32'h0);
    chk("reset data_ex_mem", data_ex_mem, 32'h0);
    chk("reset mem_fault", mem_fault, 1'b0);
    chk_en = 1'b1;

    // ALU op: one cycle in MEM, no stall.
    step();
    set_ex(1'b1, 32'h10, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
    step();
    set_nop();
    @(negedge clk);
    chk("alu stall", stall_out, 1'b0);
    chk("alu fwd", data_ex_mem, 32'h10);
    step();
    @(negedge clk);
    chk("alu wb_valid", wb_valid, 1'b1);
    chk("alu wb_data", data_mem_wb, 32'h10);
    chk("alu wb_rd", wb_rd, 5'd3);

    // Load at 0x100, ack on the second REQ cycle.
    step();
    set_ex(1'b1, 32'h100, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0);
    step();
    set_nop();
    @(negedge clk);
    chk("ld idle stall", stall_out, 1'b1);
    chk("ld idle req", dmem.dmem_req, 1'b0);
    step();
    @(negedge clk);
    chk("ld req1 req", dmem.dmem_req, 1'b1);
    chk("ld req1 stall", stall_out, 1'b1);
    step();
    dmem.dmem_ack   = 1'b1;
    dmem.dmem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("ld req2 req", dmem.dmem_req, 1'b1);
    chk("ld req2 addr", dmem.dmem_addr, 32'h100);
    chk("ld ack stall", stall_out, 1'b0);
    step();
    dmem.dmem_ack = 1'b0;
    @(negedge clk);
    chk("ld wb_valid", wb_valid, 1'b1);
    chk("ld wb_data", data_mem_wb, 32'hDEADBEEF);
    chk("ld wb_rd", wb_rd, 5'd5);
    chk("ld req drop", dmem.dmem_req, 1'b0);

    // Store at 0x104, ack already high (ignored in IDLE) and seen on the first REQ cycle.
    step();
    set_ex(1'b1, 32'h104, 32'h55, 5'd0, 1'b0, 1'b0, 1'b1);
    dmem.dmem_ack = 1'b1;
    step();
    set_nop();
    @(negedge clk);
    chk("st idle req", dmem.dmem_req, 1'b0);
    chk("st idle stall", stall_out, 1'b1);
    step();
    @(negedge clk);
    chk("st we", dmem.dmem_we, 1'b1);
    chk("st wdata", dmem.dmem_wdata, 32'h55);
    chk("st addr", dmem.dmem_addr, 32'h104);
    step();
    dmem.dmem_ack = 1'b0;
    @(negedge clk);
    chk("st wb_valid", wb_valid, 1'b1);
    chk("st wb_reg_write", wb_reg_write, 1'b0);

    // Misaligned load at 0x102.
    step();
    set_ex(1'b1, 32'h102, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0);
    step();
    set_nop();
    @(negedge clk);
    chk("mis fault", mem_fault, 1'b1);
    chk("mis req", dmem.dmem_req, 1'b0);
    chk("mis stall", stall_out, 1'b0);
    step();
    @(negedge clk);
    chk("mis wb_valid", wb_valid, 1'b0);
    chk("mis fault end", mem_fault, 1'b0);

    // Timeout after TO_MAX request cycles.
    step();
    set_ex(1'b1, 32'h200, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0);
    step();
    set_nop();
    @(negedge clk);
    chk("to idle stall", stall_out, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      chk("to req", dmem.dmem_req, 1'b1);
      chk("to fault", mem_fault, (i == 3));
      chk("to stall", stall_out, (i != 3));
    end
    step();
    @(negedge clk);
    chk("to req drop", dmem.dmem_req, 1'b0);
    chk("to wb_valid", wb_valid, 1'b0);
    chk("to resume", stall_out, 1'b0);

    // Flush while a load waits in REQ: the load completes, the flushed op becomes a bubble.
    step();
    set_ex(1'b1, 32'h300, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
    step();
    set_ex(1'b1, 32'h44, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    chk("fl idle stall", stall_out, 1'b1);
    step();
    @(negedge clk);
    chk("fl req", dmem.dmem_req, 1'b1);
    step();
    dmem.dmem_ack   = 1'b1;
    dmem.dmem_rdata = 32'hCAFE0001;
    @(negedge clk);
    chk("fl ack stall", stall_out, 1'b0);
    step();
    dmem.dmem_ack = 1'b0;
    flush = 1'b0;
    set_nop();
    @(negedge clk);
    chk("fl ld wb_valid", wb_valid, 1'b1);
    chk("fl ld data", data_mem_wb, 32'hCAFE0001);
    chk("fl ld rd", wb_rd, 5'd7);
    step();
    @(negedge clk);
    chk("fl squashed", wb_valid, 1'b0);

    // Randomized traffic, checked every cycle by the model.
    for (int n = 0; n < 3000; n++) begin
      step();
      rst          = ($urandom_range(0, 99) == 0);
      ex_valid     = ($urandom_range(0, 3) != 0);
      ex_mem_read  = ($urandom_range(0, 2) == 0);
      ex_mem_write = ($urandom_range(0, 3) == 0);
      r = $urandom();
      if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
      ex_alu_out      = r;
      ex_st_data      = $urandom();
      ex_rd           = RW'($urandom_range(0, 31));
      ex_reg_write    = $urandom_range(0, 1) == 1;
      flush           = ($urandom_range(0, 7) == 0);
      dmem.dmem_ack   = ($urandom_range(0, 9) < 3);
      dmem.dmem_rdata = $urandom();
    end
    step();
    rst = 1'b0;
    dmem.dmem_ack = 1'b0;
    set_nop();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
